zuart_tx_feeder: RTL and testbench
==================================

Name: zuart_tx_feeder

Overview:
- Upstream stage of the UART transmitter.
- Buffers bytes from the detector's data path in a synchronous FIFO.
- Generates the one-cycle bit-rate tick (bps_clk) the transmitter needs.
- Sequences one byte at a time into the transmitter: holds tx_en/tx_data stable until the transmitter's done pulse, then releases and fetches the next byte.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (16).
- CLK_DIV, 434, clk cycles per UART bit (50 MHz / 115200); legal range ≥ 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = allowed to start new bytes; 0 = finish the current byte, then hold.
- wr_en  input  1  write strobe, one byte per cycle.
- wr_data  input  8  byte to enqueue.
- full  output  1  FIFO holds 2**DEPTH_LOG2 bytes.
- empty  output  1  FIFO holds 0 bytes.
- level  output  DEPTH_LOG2+1  current FIFO occupancy.
- ovf  output  1  sticky flag: a write was dropped.
- ovf_clr  input  1  clears ovf.
- busy  output  1  a byte is owned by the transmitter (FSM in SEND).
- bps_clk  output  1  one-cycle bit-rate tick to the transmitter.
- tx_en  output  1  transmitter enable.
- tx_data  output  8  byte presented to the transmitter.
- tx_done  input  1  one-cycle done pulse from the transmitter.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO pointers and level = 0; empty=1, full=0, ovf=0.
  - bps counter = 0, bps_clk=0.
  - FSM=IDLE, tx_en=0, tx_data=8'h00, busy=0.
  - All outputs are registered except full, empty and level, which decode from the registered count.
- Bit tick:
  - Free-running counter 0..CLK_DIV-1, wraps to 0.
  - bps_clk=1 for exactly the one cycle in which the counter equals CLK_DIV-1. Period = CLK_DIV cycles, independent of FSM state.
- FIFO write:
  - Accepted at the rising edge when wr_en=1 and full=0. Byte is stored at the write pointer, and the pointer wraps modulo depth.
  - wr_en=1 with full=1: the byte is dropped and ovf is set at that edge. A pop in the same cycle does NOT rescue the write.
- FIFO pop:
  - Performed only by the FSM, as described below.
  - A simultaneous accepted write and pop leaves level unchanged.
  - level is never negative and never exceeds depth.
- ovf:
  - Set by a dropped write; cleared by ovf_clr=1.
  - Set and clear in the same cycle: set wins.
- FSM IDLE:
  - tx_en=0.
  - If enable=1 and empty=0: at the edge, pop the head into tx_data, set tx_en=1, busy=1, go to SEND.
- FSM SEND:
  - tx_en=1 and tx_data are held constant; the FIFO is not popped.
  - tx_done=1: at the edge, tx_en=0, busy=0, go to IDLE.
  - tx_done is ignored in IDLE.
- Inter-byte gap:
  - tx_en is low for at least one full cycle between bytes, because a pop can only occur from IDLE at the edge after returning.
  - This ensures the transmitter resets its bit index and does not resend the previous byte.
- Latency: wr_en sampled into an empty FIFO at edge N, with FSM in IDLE and enable=1 → tx_en=1 and tx_data valid after edge N+1.
- Enable:
  - Dropping enable during SEND does not abort; the current byte completes on tx_done.
  - enable=0 in IDLE holds tx_en=0 while writes continue to fill the FIFO.
- Byte ordering: strictly FIFO. Every accepted byte is presented exactly once.

Test Plan:
- Reset then idle 3*CLK_DIV cycles → bps_clk pulses exactly every 434 cycles, one cycle wide. tx_en=0, empty=1, level=0.
- Write 8'hA5 with enable=1, model transmitter asserting tx_done 11 bps ticks later → tx_en rises 2 edges after write with tx_data=A5. tx_en falls the edge after tx_done. busy tracks tx_en.
- Burst-write 8'h01..8'h05 back-to-back → tx_data sequence 01,02,03,04,05. tx_en low ≥1 cycle between bytes. level decrements 5→0.
- enable=0, write 17 bytes → level=16, full=1, ovf=1, 17th byte absent from output. Pulse ovf_clr together with an 18th dropped write → ovf stays 1. ovf_clr alone → ovf=0.
- Deassert enable mid-SEND → current byte finishes on tx_done, tx_en stays 0 afterwards. Reassert → next byte starts the edge after.
- Assert rst_n=0 mid-SEND with 3 bytes queued → tx_en=0, level=0, ovf=0 immediately (asynchronous). After release, no stale byte is sent.

Source files
------------

// File: rtl/zuart_tx_feeder.sv
// zuart_tx_feeder: byte FIFO, bit-rate tick generator and one-byte-at-a-time
// sequencer feeding the UART transmitter. tx_en/tx_data are held while the
// transmitter owns a byte and are released on its tx_done pulse.
module zuart_tx_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int CLK_DIV    = 434
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  ovf,
    input  logic                  ovf_clr,
    output logic                  busy,
    output logic                  bps_clk,
    output logic                  tx_en,
    output logic [7:0]            tx_data,
    input  logic                  tx_done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] BPS_LAST = CW'(CLK_DIV - 1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    // ---------------- bit-rate tick ----------------
    logic [CW-1:0] bps_cnt_q, bps_cnt_d;
    logic          bps_clk_q;

    // Free-running divider; wraps after CLK_DIV-1
    always_comb begin
        bps_cnt_d = (bps_cnt_q == BPS_LAST) ? '0 : bps_cnt_q + CW'(1);
    end

    // Tick is registered so it is high exactly while the counter sits at CLK_DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bps_cnt_q <= '0;
            bps_clk_q <= 1'b0;
        end else begin
            bps_cnt_q <= bps_cnt_d;
            bps_clk_q <= (bps_cnt_d == BPS_LAST);
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  wr_acc, wr_drop, pop;
    logic                  ovf_q, ovf_d;

    assign full    = (cnt_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    // Full is judged before this edge's pop, so a same-cycle pop never rescues a write
    assign wr_acc  = wr_en & ~full;
    assign wr_drop = wr_en & full;

    // Occupancy and sticky overflow next-state; a drop beats a clear
    always_comb begin
        cnt_d = cnt_q;
        case ({wr_acc, pop})
            2'b10:   cnt_d = cnt_q + (DEPTH_LOG2+1)'(1);
            2'b01:   cnt_d = cnt_q - (DEPTH_LOG2+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q;
        if (wr_drop)      ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    // Storage array: data only, no reset needed
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wptr_q] <= wr_data;
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_acc) wptr_q <= wptr_q + DEPTH_LOG2'(1);
            if (pop)    rptr_q <= rptr_q + DEPTH_LOG2'(1);
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // ---------------- sequencer FSM ----------------
    state_t     state_q, state_d;
    logic       tx_en_q, tx_en_d;
    logic       busy_q, busy_d;
    logic [7:0] tx_data_q, tx_data_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state: start only from IDLE, so tx_en always drops for a cycle between bytes
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable && !empty) state_d = S_SEND;
            S_SEND:  if (tx_done)          state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: pop the head on the IDLE->SEND edge and latch it until the next pop
    always_comb begin
        pop       = (state_q == S_IDLE) && enable && !empty;
        tx_en_d   = (state_d == S_SEND);
        busy_d    = (state_d == S_SEND);
        tx_data_d = pop ? mem_q[rptr_q] : tx_data_q;
    end

    // Registered transmitter-facing outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            tx_en_q   <= tx_en_d;
            busy_q    <= busy_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign tx_en   = tx_en_q;
    assign busy    = busy_q;
    assign tx_data = tx_data_q;
    assign ovf     = ovf_q;
    assign bps_clk = bps_clk_q;

endmodule

// File: tb/tb_zuart_tx_feeder.sv
// Bench for zuart_tx_feeder: queue-based reference model of the FIFO, the
// one-byte-owned transmitter handshake and the bit tick, checked every cycle.
module tb_zuart_tx_feeder;

    localparam int DL      = 4;
    localparam int DEPTH   = 16;
    localparam int CLK_DIV = 434;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          ovf_clr = 1'b0;
    logic          tx_done = 1'b0;
    logic          full, empty, ovf, busy, bps_clk, tx_en;
    logic [DL:0]   level;
    logic [7:0]    tx_data;

    zuart_tx_feeder #(.DEPTH_LOG2(DL), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level), .ovf(ovf), .ovf_clr(ovf_clr),
        .busy(busy), .bps_clk(bps_clk), .tx_en(tx_en), .tx_data(tx_data), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [7:0] m_q[$];
    bit         m_send = 0;
    logic [7:0] m_data = 8'h00;
    bit         m_ovf = 0;
    int         m_cyc = 0;

    int         n_assert = 0;
    int         n_fail = 0;
    logic [7:0] dut_log[$];
    bit         prev_tx_en = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_send = 0;
        m_data = 8'h00;
        m_ovf  = 0;
        m_cyc  = 0;
    endfunction

    // What one rising edge does, given the inputs presented to it
    function automatic void model_edge();
        bit full_pre;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_cyc++;
        full_pre = (m_q.size() == DEPTH);
        if (!m_send && enable && m_q.size() > 0) begin
            m_data = m_q.pop_front();
            m_send = 1;
        end else if (m_send && tx_done) begin
            m_send = 0;
        end
        if (wr_en && !full_pre) m_q.push_back(wr_data);
        if (wr_en && full_pre) m_ovf = 1;
        else if (ovf_clr)      m_ovf = 0;
    endfunction

    task automatic check_all();
        chk("tx_en",   tx_en,   m_send);
        chk("busy",    busy,    m_send);
        chk("tx_data", tx_data, m_data);
        chk("level",   level,   m_q.size());
        chk("full",    full,    m_q.size() == DEPTH);
        chk("empty",   empty,   m_q.size() == 0);
        chk("ovf",     ovf,     m_ovf);
        chk("bps_clk", bps_clk, rst_n && (m_cyc % CLK_DIV == CLK_DIV - 1));
        if (tx_en && !prev_tx_en) dut_log.push_back(tx_data);
        prev_tx_en = tx_en;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Run n cycles with a transmitter stand-in that pulses tx_done after a random hold
    task automatic run_auto(input int n);
        int cnt = 0;
        int dly = $urandom_range(1, 8);
        repeat (n) begin
            tx_done = 1'b0;
            if (m_send) begin
                cnt++;
                if (cnt >= dly) begin
                    tx_done = 1'b1;
                    cnt = 0;
                    dly = $urandom_range(1, 8);
                end
            end
            tick();
        end
        tx_done = 1'b0;
    endtask

    initial begin
        int         pulses, last, t;
        logic [7:0] wb[17];
        logic [7:0] x, y;

        // ---- reset and free-running tick ----
        #2 rst_n = 1'b0;
        #1 check_all();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        last = -1;
        repeat (3 * CLK_DIV) begin
            tick();
            if (bps_clk) begin
                pulses++;
                if (last >= 0) chk("bps_period", m_cyc - last, CLK_DIV);
                last = m_cyc;
            end
        end
        chk("bps_pulses", pulses, 3);
        chk("idle_tx_en", tx_en, 1'b0);
        chk("idle_empty", empty, 1'b1);

        // ---- single byte, done after 11 bit ticks ----
        enable = 1'b1;
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        chk("lat_edgeN", tx_en, 1'b0);
        tick();
        chk("lat_edgeN1", tx_en, 1'b1);
        chk("lat_data", tx_data, 8'hA5);
        t = 0;
        for (int i = 0; i < 12 * CLK_DIV && t < 11; i++) begin
            tick();
            if (bps_clk) t++;
        end
        chk("wait_11_ticks", t, 11);
        chk("held_tx_en", tx_en, 1'b1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("fall_tx_en", tx_en, 1'b0);
        chk("fall_busy", busy, 1'b0);

        // ---- burst 01..05 ----
        dut_log.delete();
        for (int b = 1; b <= 5; b++) begin
            wr_en = 1'b1; wr_data = 8'(b);
            tick();
        end
        wr_en = 1'b0;
        run_auto(200);
        chk("burst_count", dut_log.size(), 5);
        for (int i = 0; i < 5 && i < dut_log.size(); i++)
            chk("burst_order", dut_log[i], i + 1);

        // ---- overflow with enable low ----
        enable = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wb[i] = 8'($urandom);
            wr_en = 1'b1; wr_data = wb[i];
            tick();
        end
        wr_en = 1'b0;
        chk("ovf_level", level, 16);
        chk("ovf_full", full, 1'b1);
        chk("ovf_set", ovf, 1'b1);
        ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'($urandom);
        tick();
        chk("ovf_set_wins", ovf, 1'b1);
        wr_en = 1'b0;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 1'b0);
        dut_log.delete();
        enable = 1'b1;
        run_auto(300);
        chk("drain_count", dut_log.size(), 16);
        for (int i = 0; i < 16 && i < dut_log.size(); i++)
            chk("drain_order", dut_log[i], wb[i]);

        // ---- enable dropped mid-SEND ----
        x = 8'($urandom); y = 8'($urandom);
        wr_en = 1'b1; wr_data = x; tick();
        wr_data = y; tick();
        wr_en = 1'b0;
        chk("send_x", tx_en, 1'b1);
        enable = 1'b0;
        repeat (3) tick();
        chk("no_abort", tx_en, 1'b1);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        chk("done_x", tx_en, 1'b0);
        repeat (5) tick();
        chk("hold_off", tx_en, 1'b0);
        chk("hold_level", level, 1);
        enable = 1'b1;
        tick();
        chk("resume_en", tx_en, 1'b1);
        chk("resume_data", tx_data, y);
        run_auto(30);

        // ---- async reset mid-SEND with 3 queued ----
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            tick();
        end
        wr_en = 1'b0;
        chk("pre_rst_send", tx_en, 1'b1);
        chk("pre_rst_level", level, 3);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_tx_en", tx_en, 1'b0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_busy", busy, 1'b0);
        prev_tx_en = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        dut_log.delete();
        run_auto(20);
        chk("no_stale", dut_log.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
